id_ex_stage_pipe: RTL and testbench

Registered decode/operand-select stage for ARM-style data-processing instructions, sitting between register-file read (ID) and the shifter/ALU (EX). It decodes three instruction classes: register shift by immediate, register shift by register, and rotated 8-bit immediate. It selects the shifter data, shift amount and ALU A operand, with optional write-back forwarding. Results are held in a pipeline register with a valid/ready handshake, stall support and flush.

---
 rtl/id_ex_stage_pipe.sv | 121 ++++++++++++
 tb/tb_id_ex_stage_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_pipe.sv
// ID->EX pipeline register for ARM-style data-processing instructions.
// Decodes the shifter/ALU operand selection and holds it behind a valid/ready handshake.
module id_ex_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int SHNUM_W = 8,
  parameter int REG_AW  = 4,
  parameter int FWD_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst,
  input  logic [DATA_W-1:0]   data_a,
  input  logic [DATA_W-1:0]   data_b,
  input  logic [DATA_W-1:0]   data_c,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   shift_data,
  output logic [DATA_W-1:0]   alu_a,
  output logic [SHNUM_W-1:0]  shift_num,
  output logic [2:0]          shift_op,
  output logic [3:0]          alu_op,
  output logic                s_flag,
  output logic [3:0]          cond,
  output logic [REG_AW-1:0]   addr_a,
  output logic [REG_AW-1:0]   addr_b,
  output logic [REG_AW-1:0]   addr_c,
  output logic [REG_AW-1:0]   w_addr,
  output logic                write_reg,
  output logic                illegal
);

  logic [REG_AW-1:0]  fld_a, fld_b, fld_c, fld_w;
  logic [DATA_W-1:0]  op_a, op_b, op_c;
  logic               is_rimm, is_rreg, is_imm, legal, load;
  logic [DATA_W-1:0]  nxt_shift_data;
  logic [SHNUM_W-1:0] nxt_shift_num;
  logic [2:0]         nxt_shift_op;

  assign fld_a = REG_AW'(inst[19:16]);
  assign fld_b = REG_AW'(inst[3:0]);
  assign fld_c = REG_AW'(inst[11:8]);
  assign fld_w = REG_AW'(inst[15:12]);

  // Each operand independently takes the write-back value when it targets the same register.
  assign op_a = (FWD_EN != 0 && wb_en && wb_addr == fld_a) ? wb_data : data_a;
  assign op_b = (FWD_EN != 0 && wb_en && wb_addr == fld_b) ? wb_data : data_b;
  assign op_c = (FWD_EN != 0 && wb_en && wb_addr == fld_c) ? wb_data : data_c;

  assign is_rimm = (inst[27:25] == 3'b000) && !inst[4];
  assign is_rreg = (inst[27:25] == 3'b000) && inst[4] && !inst[7];
  assign is_imm  = (inst[27:25] == 3'b001);
  assign legal   = (is_rimm || is_rreg || is_imm) && (inst[15:12] != 4'b1111);

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    nxt_shift_data = op_b;
    nxt_shift_num  = '0;
    nxt_shift_op   = 3'b000;
    if (legal) begin
      if (is_imm) begin
        nxt_shift_data = DATA_W'(inst[7:0]);
        nxt_shift_num  = SHNUM_W'({inst[11:8], 1'b0});
        nxt_shift_op   = 3'b111;
      end else if (is_rreg) begin
        nxt_shift_num  = op_c[SHNUM_W-1:0];
        nxt_shift_op   = {inst[6:5], 1'b1};
      end else begin
        nxt_shift_num  = SHNUM_W'(inst[11:7]);
        nxt_shift_op   = {inst[6:5], 1'b0};
      end
    end
  end

  // Flush wins over a load in the same cycle; data registers only move on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      shift_data <= '0;
      alu_a      <= '0;
      shift_num  <= '0;
      shift_op   <= '0;
      alu_op     <= '0;
      s_flag     <= 1'b0;
      cond       <= '0;
      addr_a     <= '0;
      addr_b     <= '0;
      addr_c     <= '0;
      w_addr     <= '0;
      write_reg  <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      shift_data <= nxt_shift_data;
      alu_a      <= op_a;
      shift_num  <= nxt_shift_num;
      shift_op   <= nxt_shift_op;
      alu_op     <= inst[24:21];
      s_flag     <= inst[20];
      cond       <= inst[31:28];
      addr_a     <= fld_a;
      addr_b     <= fld_b;
      addr_c     <= fld_c;
      w_addr     <= fld_w;
      write_reg  <= legal;
      illegal    <= !legal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_pipe.sv
// Bench for id_ex_stage_pipe: directed cases from the decode rules plus a randomized
// handshake run against a behavioural model, with forwarding on and off.
module tb_id_ex_stage_pipe;

  typedef struct packed {
    logic [31:0] shift_data;
    logic [31:0] alu_a;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic [3:0]  alu_op;
    logic        s_flag;
    logic [3:0]  cond;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [3:0]  addr_c;
    logic [3:0]  w_addr;
    logic        write_reg;
    logic        illegal;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready, wb_en;
  logic [31:0] inst, data_a, data_b, data_c, wb_data;
  logic [3:0]  wb_addr;

  logic        in_ready, out_valid, nf_in_ready, nf_out_valid;
  logic [31:0] shift_data, alu_a, nf_shift_data, nf_alu_a;
  logic [7:0]  shift_num, nf_shift_num;
  logic [2:0]  shift_op, nf_shift_op;
  logic [3:0]  alu_op, cond, addr_a, addr_b, addr_c, w_addr;
  logic [3:0]  nf_alu_op, nf_cond, nf_addr_a, nf_addr_b, nf_addr_c, nf_w_addr;
  logic        s_flag, write_reg, illegal, nf_s_flag, nf_write_reg, nf_illegal;

  rec_t obs, obs_nf;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_stage_pipe #(.DATA_W(32), .SHNUM_W(8), .REG_AW(4), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .shift_data(shift_data), .alu_a(alu_a), .shift_num(shift_num), .shift_op(shift_op),
    .alu_op(alu_op), .s_flag(s_flag), .cond(cond), .addr_a(addr_a), .addr_b(addr_b),
    .addr_c(addr_c), .w_addr(w_addr), .write_reg(write_reg), .illegal(illegal)
  );

  id_ex_stage_pipe #(.DATA_W(32), .SHNUM_W(8), .REG_AW(4), .FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nf_in_ready), .inst(inst),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(nf_out_valid), .out_ready(out_ready),
    .shift_data(nf_shift_data), .alu_a(nf_alu_a), .shift_num(nf_shift_num),
    .shift_op(nf_shift_op), .alu_op(nf_alu_op), .s_flag(nf_s_flag), .cond(nf_cond),
    .addr_a(nf_addr_a), .addr_b(nf_addr_b), .addr_c(nf_addr_c), .w_addr(nf_w_addr),
    .write_reg(nf_write_reg), .illegal(nf_illegal)
  );

  assign obs = {shift_data, alu_a, shift_num, shift_op, alu_op, s_flag, cond,
                addr_a, addr_b, addr_c, w_addr, write_reg, illegal};
  assign obs_nf = {nf_shift_data, nf_alu_a, nf_shift_num, nf_shift_op, nf_alu_op, nf_s_flag,
                   nf_cond, nf_addr_a, nf_addr_b, nf_addr_c, nf_w_addr, nf_write_reg, nf_illegal};

  // Reference decode: classify the word, then pick operands from the class rules.
  function automatic rec_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic we, input logic [3:0] wa,
                                 input logic [31:0] wd, input bit fwd);
    rec_t r;
    logic [31:0] ra, rb, rc;
    int cls;
    bit ok;
    ra = (fwd && we && wa == i[19:16]) ? wd : a;
    rb = (fwd && we && wa == i[3:0])   ? wd : b;
    rc = (fwd && we && wa == i[11:8])  ? wd : c;
    cls = 0;
    if (i[27:25] == 3'b001) cls = 3;
    else if (i[27:25] == 3'b000 && i[4] == 1'b0) cls = 1;
    else if (i[27:25] == 3'b000 && i[7] == 1'b0) cls = 2;
    ok = (cls != 0) && (i[15:12] != 4'd15);
    r.cond = i[31:28];  r.alu_op = i[24:21];  r.s_flag = i[20];
    r.addr_a = i[19:16]; r.addr_b = i[3:0]; r.addr_c = i[11:8]; r.w_addr = i[15:12];
    r.alu_a = ra;
    r.write_reg = ok;
    r.illegal = !ok;
    r.shift_data = rb;
    r.shift_num = 8'd0;
    r.shift_op = 3'b000;
    if (ok && cls == 1) begin
      r.shift_num = 8'(i[11:7]);
      r.shift_op = {i[6:5], 1'b0};
    end else if (ok && cls == 2) begin
      r.shift_num = rc[7:0];
      r.shift_op = {i[6:5], 1'b1};
    end else if (ok && cls == 3) begin
      r.shift_data = 32'(i[7:0]);
      r.shift_num = 8'(i[11:8]) * 8'd2;
      r.shift_op = 3'b111;
    end
    return r;
  endfunction

  task automatic drive_one(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic we, input logic [3:0] wa,
                           input logic [31:0] wd);
    @(negedge clk);
    inst = i; data_a = a; data_b = b; data_c = c;
    wb_en = we; wb_addr = wa; wb_data = wd;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state valid=%b outputs=%h want valid=0 outputs=0", out_valid, obs);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_r_imm;
    rec_t e;
    drive_one(32'hE0812283, 32'd10, 32'd7, 32'd0, 1'b0, 4'd0, 32'd0);
    e = '0;
    e.alu_a = 32'd10; e.shift_data = 32'd7; e.shift_num = 8'd5; e.shift_op = 3'b000;
    e.alu_op = 4'b0100; e.cond = 4'hE; e.addr_a = 4'd1; e.addr_b = 4'd3; e.addr_c = 4'd2;
    e.w_addr = 4'd2; e.write_reg = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      errors++;
      $display("[TB] FAIL r_imm valid=%b got=%h want valid=1 %h", out_valid, obs, e);
    end
  endtask

  task automatic test_r_reg_fwd;
    rec_t e;
    drive_one(32'hE0812413, 32'h11, 32'h22, 32'd0, 1'b1, 4'd4, 32'h1F3);
    e = '0;
    e.alu_a = 32'h11; e.shift_data = 32'h22; e.shift_num = 8'hF3; e.shift_op = 3'b001;
    e.alu_op = 4'b0100; e.cond = 4'hE; e.addr_a = 4'd1; e.addr_b = 4'd3; e.addr_c = 4'd4;
    e.w_addr = 4'd2; e.write_reg = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      errors++;
      $display("[TB] FAIL r_reg_fwd valid=%b got=%h want valid=1 %h", out_valid, obs, e);
    end
    e.shift_num = 8'h00;
    checks++;
    if (nf_out_valid !== 1'b1 || obs_nf !== e) begin
      errors++;
      $display("[TB] FAIL r_reg_nofwd valid=%b got=%h want valid=1 %h", nf_out_valid, obs_nf, e);
    end
  endtask

  task automatic test_imm;
    rec_t e;
    drive_one(32'hE3A014FF, 32'h55, 32'h66, 32'h77, 1'b0, 4'd0, 32'd0);
    e = '0;
    e.alu_a = 32'h55; e.shift_data = 32'h000000FF; e.shift_num = 8'd8; e.shift_op = 3'b111;
    e.alu_op = 4'b1101; e.cond = 4'hE; e.addr_a = 4'd0; e.addr_b = 4'hF; e.addr_c = 4'd4;
    e.w_addr = 4'd1; e.write_reg = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      errors++;
      $display("[TB] FAIL imm valid=%b got=%h want valid=1 %h", out_valid, obs, e);
    end
  endtask

  task automatic test_illegal;
    rec_t e;
    drive_one(32'hE081F003, 32'h10, 32'h20, 32'h30, 1'b0, 4'd0, 32'd0);
    e = '0;
    e.alu_a = 32'h10; e.shift_data = 32'h20; e.alu_op = 4'b0100; e.cond = 4'hE;
    e.addr_a = 4'd1; e.addr_b = 4'd3; e.addr_c = 4'd0; e.w_addr = 4'hF; e.illegal = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      errors++;
      $display("[TB] FAIL illegal_rd15 valid=%b got=%h want valid=1 %h", out_valid, obs, e);
    end
    drive_one(32'hE5912003, 32'h10, 32'h20, 32'h30, 1'b0, 4'd0, 32'd0);
    e = '0;
    e.alu_a = 32'h10; e.shift_data = 32'h20; e.alu_op = 4'b1100; e.s_flag = 1'b1;
    e.cond = 4'hE; e.addr_a = 4'd1; e.addr_b = 4'd3; e.w_addr = 4'd2; e.illegal = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      errors++;
      $display("[TB] FAIL illegal_class010 valid=%b got=%h want valid=1 %h", out_valid, obs, e);
    end
    drive_one(32'hE0010392, 32'h10, 32'h20, 32'h30, 1'b0, 4'd0, 32'd0);
    checks++;
    if (illegal !== 1'b1 || write_reg !== 1'b0 || shift_op !== 3'b000 || shift_num !== 8'd0) begin
      errors++;
      $display("[TB] FAIL illegal_bit7 illegal=%b write_reg=%b op=%b num=%h want 1 0 000 00",
               illegal, write_reg, shift_op, shift_num);
    end
  endtask

  task automatic test_stall_flush;
    rec_t e;
    @(negedge clk);
    inst = 32'hE0812283; data_a = 32'd10; data_b = 32'd7; wb_en = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    inst = 32'hE3A014FF; data_a = 32'd99;
    e = '0;
    e.alu_a = 32'd10; e.shift_data = 32'd7; e.shift_num = 8'd5; e.alu_op = 4'b0100;
    e.cond = 4'hE; e.addr_a = 4'd1; e.addr_b = 4'd3; e.addr_c = 4'd2; e.w_addr = 4'd2;
    e.write_reg = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== e) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d valid=%b in_ready=%b got=%h want 1 0 %h",
                 k, out_valid, in_ready, obs, e);
      end
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush valid=%b in_ready=%b want valid=0 in_ready=1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_no_load valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    inst = 32'hE3A014FF; data_a = 32'h1234; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_stall valid=%b outputs=%h want 0 and 0", out_valid, obs);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  // Random traffic with random stalls and flushes; model tracks the register contents.
  task automatic test_random;
    bit   mv = 1'b0;
    rec_t mrec, mrec_nf;
    logic [31:0] r;
    int sel;
    mrec = '0;
    mrec_nf = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (out_valid !== mv || nf_out_valid !== mv) begin
        errors++;
        $display("[TB] FAIL rand_valid_%0d got=%b/%b want=%b", n, out_valid, nf_out_valid, mv);
      end
      if (mv) begin
        checks++;
        if (obs !== mrec) begin
          errors++;
          $display("[TB] FAIL rand_data_%0d got=%h want=%h", n, obs, mrec);
        end
        checks++;
        if (obs_nf !== mrec_nf) begin
          errors++;
          $display("[TB] FAIL rand_data_nf_%0d got=%h want=%h", n, obs_nf, mrec_nf);
        end
      end
      r = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4) r[27:25] = 3'b000;
      else if (sel < 7) r[27:25] = 3'b001;
      inst = r;
      data_a = $urandom; data_b = $urandom; data_c = $urandom;
      wb_en = 1'($urandom_range(0, 1));
      wb_data = $urandom;
      case ($urandom_range(0, 3))
        0: wb_addr = r[19:16];
        1: wb_addr = r[3:0];
        2: wb_addr = r[11:8];
        default: wb_addr = 4'($urandom);
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (in_ready !== (!mv || out_ready)) begin
        errors++;
        $display("[TB] FAIL rand_in_ready_%0d got=%b want=%b", n, in_ready, (!mv || out_ready));
      end
      if (flush) mv = 1'b0;
      else if (in_valid && (!mv || out_ready)) begin
        mv = 1'b1;
        mrec = model(inst, data_a, data_b, data_c, wb_en, wb_addr, wb_data, 1'b1);
        mrec_nf = model(inst, data_a, data_b, data_c, wb_en, wb_addr, wb_data, 1'b0);
      end else if (mv && out_ready) mv = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    inst = '0; data_a = '0; data_b = '0; data_c = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    test_reset;
    test_r_imm;
    test_r_reg_fwd;
    test_imm;
    test_illegal;
    test_stall_flush;
    test_reset_mid_stall;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
